// File: rtl/sprite_pkg.sv
// Shared FSM encoding and default sprite layout for the texture ROM.
package sprite_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StStream,
      StDone
   } state_e;

   // Default layout: t-rex bytes first, obstacle bytes packed directly after
   localparam logic [9:0] TrexBase = 10'd0;
   localparam logic [6:0] TrexLen  = 7'd69;
   localparam logic [9:0] ObstBase = 10'd69;
   localparam logic [6:0] ObstLen  = 7'd43;

endpackage

// File: rtl/sprite_fetch.sv
// Streams one sprite from an external combinational texture ROM to a display
// writer over a valid/ready channel, one byte per cycle, with column tags.
module sprite_fetch
   import sprite_pkg::*;
#(
   parameter logic [9:0] TREX_BASE = TrexBase,
   parameter logic [6:0] TREX_LEN  = TrexLen,
   parameter logic [9:0] OBST_BASE = ObstBase,
   parameter logic [6:0] OBST_LEN  = ObstLen
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       sprite_sel,
   input  logic [6:0] x_pos,
   input  logic       abort,
   output logic [9:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [6:0] out_col,
   output logic       out_last,
   output logic       busy,
   output logic       done
);

   state_e     state_q, state_d;
   logic [9:0] base_q, base_d;
   logic [6:0] len_q, len_d;
   logic [6:0] xpos_q, xpos_d;
   logic [6:0] idx_q, idx_d;
   logic [7:0] data_q, data_d;
   logic [6:0] col_q, col_d;
   logic       valid_q, valid_d;
   logic       last_q, last_d;

   logic       hs;

   assign hs = valid_q & out_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort wins over a coincident handshake
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (start) state_d = StLoad;
         StLoad:   state_d = abort ? StIdle : StStream;
         StStream: begin
            if (abort) begin
               state_d = StIdle;
            end else if (hs && last_q) begin
               state_d = StDone;
            end
         end
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs decoded from state and the latched transfer context
   always_comb begin
      busy     = (state_q != StIdle);
      done     = (state_q == StDone);
      rom_addr = (state_q == StIdle) ? 10'd0 : base_q + {3'b000, idx_q};
   end

   // Datapath next-state: latch request, then walk the sprite one byte per handshake
   always_comb begin
      base_d  = base_q;
      len_d   = len_q;
      xpos_d  = xpos_q;
      idx_d   = idx_q;
      data_d  = data_q;
      col_d   = col_q;
      valid_d = valid_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               base_d = sprite_sel ? OBST_BASE : TREX_BASE;
               len_d  = sprite_sel ? OBST_LEN : TREX_LEN;
               xpos_d = x_pos;
               idx_d  = 7'd0;
            end
         end
         StLoad: begin
            if (abort) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
            end else begin
               data_d  = rom_data;
               col_d   = xpos_q;
               idx_d   = 7'd1;
               valid_d = 1'b1;
               last_d  = (len_q == 7'd1);
            end
         end
         StStream: begin
            if (abort) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
            end else if (hs) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  data_d = rom_data;
                  col_d  = col_q + 7'd1;  // 7-bit wrap, no clipping
                  idx_d  = idx_q + 7'd1;
                  last_d = (idx_q == len_q - 7'd1);
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q  <= 10'd0;
         len_q   <= 7'd0;
         xpos_q  <= 7'd0;
         idx_q   <= 7'd0;
         data_q  <= 8'h00;
         col_q   <= 7'd0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         base_q  <= base_d;
         len_q   <= len_d;
         xpos_q  <= xpos_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         col_q   <= col_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_col   = col_q;
   assign out_last  = last_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch: stimulus pushes expected bytes, a
// negedge monitor pops and compares on every accepted handshake.
module tb_sprite_fetch;

   typedef struct packed {
      logic [7:0] d;
      logic [6:0] c;
      logic       l;
   } item_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       sprite_sel;
   logic [6:0] x_pos;
   logic       abort;
   logic [9:0] rom_addr;
   logic [7:0] rom_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [6:0] out_col;
   logic       out_last;
   logic       busy;
   logic       done;

   logic [7:0] rom_mem [0:1023];
   item_t      exp_q[$];
   item_t      acc_q[$];
   int         total = 0;
   int         bad = 0;
   int         done_cnt = 0;
   logic       pend_done = 1'b0;
   logic       prev_stall = 1'b0;
   item_t      prev_item;

   sprite_fetch dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sprite_sel(sprite_sel),
      .x_pos     (x_pos),
      .abort     (abort),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_col   (out_col),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   assign rom_data = rom_mem[rom_addr];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every accepted byte, stall stability and done timing
   always @(negedge clk) begin
      item_t cur;
      item_t exp;
      cur = '{d: out_data, c: out_col, l: out_last};
      if (!rst_n) begin
         pend_done  = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (pend_done || done) chk("done_after_last", int'(done), int'(pend_done));
         pend_done = 1'b0;
         if (prev_stall && out_valid) chk("stall_hold", int'(cur), int'(prev_item));
         if (out_valid) chk("busy_while_valid", int'(busy), 1);
         if (out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", int'(cur), 0);
            end else begin
               exp = exp_q.pop_front();
               chk("byte", int'(cur), int'(exp));
            end
            acc_q.push_back(cur);
            if (out_last) pend_done = 1'b1;
         end
         prev_stall = out_valid && !out_ready && !abort;
         prev_item  = cur;
      end
   end

   task automatic push_sprite(input logic sel, input logic [6:0] x);
      int base;
      int len;
      item_t it;
      base = sel ? 69 : 0;
      len  = sel ? 43 : 69;
      for (int i = 0; i < len; i++) begin
         it.d = rom_mem[base + i];
         it.c = 7'(int'(x) + i);
         it.l = (i == len - 1);
         exp_q.push_back(it);
      end
   endtask

   // Drives one start pulse and checks the two-cycle first-byte latency
   task automatic issue_start(input logic sel, input logic [6:0] x);
      push_sprite(sel, x);
      acc_q.delete();
      @(posedge clk); #1;
      start = 1'b1; sprite_sel = sel; x_pos = x;
      @(posedge clk); #1;
      start = 1'b0;
      chk("load_not_valid", int'(out_valid), 0);
      chk("load_busy", int'(busy), 1);
      @(posedge clk); #1;
      chk("first_valid_lat2", int'(out_valid), 1);
   endtask

   // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: stray starts in STREAM and DONE
   task automatic do_xfer(input logic sel, input logic [6:0] x, input int mode);
      int   cyc;
      int   d0;
      logic got;
      logic [3:0] pat;
      pat = 4'b1001;
      d0  = done_cnt;
      out_ready = 1'b1;
      issue_start(sel, x);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 400) begin
         if (mode == 1) out_ready = pat[cyc % 4];
         if (mode == 2) begin
            start = (cyc == 10);
            sprite_sel = ~sel;
         end
         @(posedge clk); #1;
         if (done) got = 1'b1;
         cyc++;
      end
      if (!got) chk("done_timeout", 0, 1);
      start = 1'b0;
      out_ready = 1'b1;
      if (mode == 2 && got) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         chk("start_in_done_ignored", int'(busy), 0);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("handshakes", acc_q.size(), sel ? 43 : 69);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("one_done_pulse", done_cnt - d0, 1);
   endtask

   task automatic check_trex_points();
      chk("trex_first", int'(acc_q[0]), int'({8'h01, 7'd10, 1'b0}));
      chk("trex_byte13", int'(acc_q[13]), int'({8'h87, 7'd23, 1'b0}));
      chk("trex_last", int'(acc_q[68]), int'({8'hf8, 7'd78, 1'b1}));
   endtask

   task automatic run_until_col(input logic [6:0] col);
      int cyc;
      cyc = 0;
      while (!(out_valid && out_col == col) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 200) chk("reach_col_timeout", 0, 1);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom_mem[i] = 8'((i * 37 + 11) & 255);
      rom_mem[0]   = 8'h01;
      rom_mem[13]  = 8'h87;
      rom_mem[68]  = 8'hf8;
      rom_mem[69]  = 8'h03;
      rom_mem[97]  = 8'h3c;
      rom_mem[111] = 8'h80;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      sprite_sel = 1'b0; x_pos = 7'd0;
      #12;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_col", int'(out_col), 0);
      chk("rst_addr", int'(rom_addr), 0);
      @(posedge clk); #3;
      rst_n = 1'b1;

      // Full t-rex at column 10
      do_xfer(1'b0, 7'd10, 0);
      check_trex_points();

      // Obstacle at column 100, wraps past 127
      do_xfer(1'b1, 7'd100, 0);
      chk("obst_first", int'(acc_q[0]), int'({8'h03, 7'd100, 1'b0}));
      chk("obst_byte28", int'(acc_q[28]), int'({8'h3c, 7'd0, 1'b0}));
      chk("obst_last", int'(acc_q[42]), int'({8'h80, 7'd14, 1'b1}));

      // Back-pressure pattern
      do_xfer(1'b0, 7'd10, 1);
      check_trex_points();

      // Stray starts mid-stream and in DONE
      do_xfer(1'b0, 7'd10, 2);
      check_trex_points();

      // Abort coincident with the handshake of byte 5
      out_ready = 1'b1;
      issue_start(1'b0, 7'd40);
      run_until_col(7'd45);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_valid", int'(out_valid), 0);
      chk("abort_last", int'(out_last), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_accepted", acc_q.size(), 5);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      do_xfer(1'b0, 7'd10, 0);
      check_trex_points();

      // Asynchronous reset at byte 20
      issue_start(1'b0, 7'd10);
      run_until_col(7'd30);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(out_valid), 0);
      chk("arst_last", int'(out_last), 0);
      chk("arst_data", int'(out_data), 0);
      chk("arst_col", int'(out_col), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_addr", int'(rom_addr), 0);
      exp_q.delete();
      acc_q.delete();
      @(posedge clk); #3;
      rst_n = 1'b1;
      do_xfer(1'b0, 7'd10, 0);
      check_trex_points();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 SHALL have parameter TREX_BASE, default 10'd0, meaning ROM address of first t-rex byte.
REQ-002 SHALL have parameter TREX_LEN, default 7'd69, meaning t-rex byte count.
REQ-003 SHALL have parameter OBST_BASE, default 10'd69, meaning ROM address of first obstacle byte.
REQ-004 SHALL have parameter OBST_LEN, default 7'd43, meaning obstacle byte count.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  request one sprite transfer, single-cycle qualifier.
REQ-008 sprite_sel  in  1  0 = t-rex, 1 = obstacle; sampled with accepted start.
REQ-009 x_pos  in  7  display column of first byte; sampled with accepted start.
REQ-010 abort  in  1  synchronous cancel of a transfer in progress.
REQ-011 rom_addr  out  10  address to the combinational texture ROM.
REQ-012 rom_data  in  8  same-cycle byte returned by the texture ROM.
REQ-013 out_valid  out  1  out_data/out_col/out_last are valid.
REQ-014 out_ready  in  1  downstream display writer accepts the byte.
REQ-015 out_data  out  8  sprite byte.
REQ-016 out_col  out  7  display column of out_data.
REQ-017 out_last  out  1  out_data is the final byte of the sprite.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse after the last byte is accepted.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, STREAM and DONE.
REQ-021 IDLE: start=1 SHALL latch base, len, x_pos, clear index idx to 0 and go to LOAD; start outside IDLE SHALL be ignored.
REQ-022 rom_addr SHALL equal latched base + idx combinationally, and 10'd0 in IDLE.
REQ-023 LOAD: out_data<=rom_data, out_col<=x_pos, idx<=1, out_valid<=1, out_last<=(len==1), next STREAM; first byte is valid 2 cycles after start.
REQ-024 STREAM: out_data, out_col and out_last SHALL hold while out_valid=1 and out_ready=0.
REQ-025 STREAM handshake on a non-last byte: out_data<=rom_data, out_col<=out_col+1 modulo 128, idx<=idx+1, out_last<=(idx==len-1), out_valid stays 1, giving 1 byte/cycle throughput.
REQ-026 STREAM handshake on the last byte: out_valid<=0, out_last<=0, next DONE.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; start in DONE is ignored.
REQ-028 abort in LOAD or STREAM: next IDLE, out_valid=0, out_last=0, no done pulse; abort has priority over a simultaneous handshake; abort in IDLE/DONE has no effect.
REQ-029 Column arithmetic SHALL be 7-bit wrap-around (127+1=0); no clipping.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, out_valid=0, out_last=0, done=0, out_data=8'h00, out_col=0, idx=0, busy=0, including mid-transfer.
REQ-031 After rst_n deasserts, the first start SHALL be accepted no earlier than the next rising edge.

Structure
REQ-032 The state enum and the sprite base/length constants SHALL live in shared package sprite_pkg.
REQ-033 The texture ROM SHALL stay external; no sub-module SHALL be instantiated.

Verification
REQ-034 start, sel=0, x_pos=10, out_ready=1 -> 69 bytes; first 8'h01 col 10; byte 13 8'h87 col 23; last 8'hf8 col 78 with out_last; done one cycle later.
REQ-035 start, sel=1, x_pos=100 -> 43 bytes; first 8'h03 col 100; byte 28 8'h3c col 0 (wrap); last 8'h80 col 14 with out_last.
REQ-036 out_ready toggled 1,0,0,1 during a t-rex transfer -> out_data/out_col stable while stalled, no byte lost or duplicated, 69 handshakes total.
REQ-037 start pulsed during STREAM and in DONE -> ignored; exactly one done pulse, busy never drops mid-transfer.
REQ-038 abort at byte 5 coincident with a handshake -> IDLE next cycle, out_valid=0, no done; fresh start then delivers a complete sprite.
REQ-039 rst_n low at byte 20 -> outputs at reset values asynchronously; after release a new start behaves as in REQ-034.
